seq_bin_divider: RTL and testbench

SEQ_BIN_DIVIDER -- requirements
Module: seq_bin_divider

---
 rtl/seq_div_pkg.sv | 19 +
 rtl/seq_bin_divider_comb_sub_stage.sv | 29 ++
 rtl/seq_bin_divider.sv | 158 +++++++++++++++
 tb/tb_seq_bin_divider.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_pkg
// Description : Shared constants for the sequential restoring divider:
//               default operand width and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seq_bin_divider_comb_sub_stage.sv
`default_nettype none
// ============================================================================
// Module      : comb_sub_stage
// Description : Combinational (WIDTH+1)-bit trial subtractor for one
//               restoring-division step.
// Ports       : minuend    in  [WIDTH:0]    shifted partial remainder
//               subtrahend in  [WIDTH-1:0]  latched divisor
//               diff       out [WIDTH:0]    minuend - {0,subtrahend}
//               negative   out              borrow (trial result < 0)
// Revision    : 1.0 - initial release
// ============================================================================
module comb_sub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH:0]   diff,
  output logic             negative
);

  // One extra bit on top captures the borrow out of the subtraction.
  logic [WIDTH+1:0] full_diff;

  assign full_diff = {1'b0, minuend} - {2'b00, subtrahend};
  assign diff      = full_diff[WIDTH:0];
  assign negative  = full_diff[WIDTH+1];

endmodule
`default_nettype wire

// File: rtl/seq_bin_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_bin_divider
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock. Results appear with a one-cycle done pulse and hold
//               until the next accepted start.
// Config      : SEQ_BIN_DIVIDER_DIV_ZERO_EN - when defined, a zero divisor
//               bypasses the iteration and flags div_zero with a
//               single-cycle latency.
// Ports       : clk        in   clock, rising edge
//               rst_n      in   synchronous active-low reset
//               start      in   begin a division (ignored while busy)
//               dividend   in   [WIDTH-1:0] unsigned dividend
//               divisor    in   [WIDTH-1:0] unsigned divisor
//               quotient   out  [WIDTH-1:0] result, valid from done
//               remainder  out  [WIDTH-1:0] result, valid from done
//               busy       out  high during iteration cycles
//               done       out  one-cycle result-valid pulse
//               div_zero   out  divisor-was-zero flag, valid with done
// Revision    : 1.0 - initial release
// ============================================================================
module seq_bin_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt;
  logic             div_zero_reg;

  logic             accept;
  logic             zero_skip;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH:0]   trial;
  logic             trial_neg;

  // Starts arriving mid-iteration are dropped so operands are never clobbered.
  assign accept = start && (state != ST_CALC);

`ifdef SEQ_BIN_DIVIDER_DIV_ZERO_EN
  assign zero_skip = (divisor == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // {P,Q} shifted left by one; the old MSB of P is always 0 because the
  // restoring step keeps P < D.
  assign p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign q_shift = {q_reg[WIDTH-2:0], 1'b0};

  comb_sub_stage #(
    .WIDTH (WIDTH)
  ) u_sub (
    .minuend    (p_shift),
    .subtrahend (d_reg),
    .diff       (trial),
    .negative   (trial_neg)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = zero_skip ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (cnt == CW'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (accept) state_next = zero_skip ? ST_DONE : ST_CALC;
        else        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_CALC: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_reg        <= '0;
      q_reg        <= '0;
      d_reg        <= '0;
      cnt          <= '0;
      div_zero_reg <= 1'b0;
    end else if (accept) begin
      d_reg        <= divisor;
      div_zero_reg <= zero_skip;
      if (zero_skip) begin
        // Same result the iteration would produce, available immediately.
        p_reg <= {1'b0, dividend};
        q_reg <= '1;
        cnt   <= '0;
      end else begin
        p_reg <= '0;
        q_reg <= dividend;
        cnt   <= CW'(WIDTH);
      end
    end else if (state == ST_CALC) begin
      if (trial_neg) begin
        p_reg <= p_shift;
        q_reg <= q_shift;
      end else begin
        p_reg <= trial;
        q_reg <= {q_shift[WIDTH-1:1], 1'b1};
      end
      cnt <= cnt - CW'(1);
    end
  end

  assign quotient  = q_reg;
  assign remainder = p_reg[WIDTH-1:0];
  assign div_zero  = div_zero_reg;

  logic unused_p_msb;
  assign unused_p_msb = p_reg[WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_seq_bin_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_bin_divider
// Description : Self-checking bench for seq_bin_divider (WIDTH = 4) with a
//               behavioural result/latency model and directed literal cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_bin_divider;

  localparam int W = 4;
`ifdef SEQ_BIN_DIVIDER_DIV_ZERO_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  always #5 clk = ~clk;

  seq_bin_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic results; a zero divisor yields all ones / dividend.
  function automatic logic [W-1:0] res_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? {W{1'b1}} : a / b;
  endfunction

  function automatic logic [W-1:0] res_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  // Behavioural model: tracks remaining iteration cycles and the result
  // that becomes visible when they run out.
  bit           armed = 1'b0;
  bit           m_known = 1'b0;
  bit           m_done = 1'b0;
  bit           m_z = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0, pend_q = '0, pend_r = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      armed   <= 1'b1;
      m_left  <= 0;
      m_done  <= 1'b0;
      m_known <= 1'b1;
      m_q     <= '0;
      m_r     <= '0;
      m_z     <= 1'b0;
    end else if (start && m_left == 0) begin
      pend_q <= res_q(dividend, divisor);
      pend_r <= res_r(dividend, divisor);
      if (ZSKIP && divisor == '0) begin
        m_left  <= 0;
        m_done  <= 1'b1;
        m_known <= 1'b1;
        m_q     <= res_q(dividend, divisor);
        m_r     <= res_r(dividend, divisor);
        m_z     <= 1'b1;
      end else begin
        m_left  <= W;
        m_done  <= 1'b0;
        m_known <= 1'b0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done  <= 1'b1;
        m_known <= 1'b1;
        m_q     <= pend_q;
        m_r     <= pend_r;
        m_z     <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      if (m_known) begin
        check("quotient", quotient, m_q);
        check("remainder", remainder, m_r);
        check("div_zero", div_zero, m_z);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input bit lit, input int exp_lat,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez,
                        input bit noise, input int pulse_lat);
    int lat = 0;
    int bc  = 0;
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      if (lat == pulse_lat) begin
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
      end else if (noise && busy && ($urandom % 3 == 0)) begin
        start = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: no done within %0d edges", lat);
    end
    if (lit) begin
      check("latency", lat, exp_lat);
      check("busy_cycles", bc, exp_lat - 1);
      check("lit_quotient", quotient, eq);
      check("lit_remainder", remainder, er);
      check("lit_div_zero", div_zero, ez);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd13, 4'd3, 1'b1, 5, 4'd4, 4'd1, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_op(4'd15, 4'd1, 1'b1, 5, 4'd15, 4'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_op(4'd2, 4'd7, 1'b1, 5, 4'd0, 4'd2, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_op(4'd0, 4'd5, 1'b1, 5, 4'd0, 4'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    run_op(4'd9, 4'd0, 1'b1, ZSKIP ? 1 : 5, 4'd15, 4'd9, ZSKIP, 1'b0, 0);
    @(negedge clk);

    // Start pulse during CALC is ignored, then back-to-back start in DONE.
    run_op(4'd13, 4'd3, 1'b1, 5, 4'd4, 4'd1, 1'b0, 1'b0, 2);
    run_op(4'd6, 4'd2, 1'b1, 5, 4'd3, 4'd0, 1'b0, 1'b0, 0);
    @(negedge clk);

    // Reset in the middle of an iteration.
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    run_op(4'd10, 4'd4, 1'b1, 5, 4'd2, 4'd2, 1'b0, 1'b0, 0);

    // Randomised operations with gaps, back-to-back starts and stray pulses.
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] a, b;
      int gap;
      a   = W'($urandom);
      b   = ($urandom % 5 == 0) ? '0 : W'($urandom);
      gap = $urandom % 3;
      repeat (gap) @(negedge clk);
      run_op(a, b, 1'b0, 0, '0, '0, 1'b0, 1'b1, 0);
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
